// File: rtl/vx_pending_scoreboard.sv
// Per-slot pending-write scoreboard: blocks instructions whose operands have
// outstanding writebacks and stages accepted instructions in a 2-entry skid buffer.
module vx_pending_scoreboard #(
   parameter int unsigned NUM_SLOTS      = 1,
   parameter int unsigned WARPS_PER_SLOT = 4,
   parameter int unsigned NUM_REGS       = 64,
   parameter int unsigned CTR_BITS       = 2,
   parameter int unsigned ALLOW_WAW      = 0,
   parameter int unsigned DATAW          = 64,
   localparam int unsigned WIS_W = (WARPS_PER_SLOT > 1) ? $clog2(WARPS_PER_SLOT) : 1,
   localparam int unsigned RW    = $clog2(NUM_REGS)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_SLOTS-1:0]         in_valid,
   output logic [NUM_SLOTS-1:0]         in_ready,
   input  logic [NUM_SLOTS*WIS_W-1:0]   in_wis,
   input  logic [NUM_SLOTS*RW-1:0]      in_rd,
   input  logic [NUM_SLOTS*RW-1:0]      in_rs1,
   input  logic [NUM_SLOTS*RW-1:0]      in_rs2,
   input  logic [NUM_SLOTS*RW-1:0]      in_rs3,
   input  logic [NUM_SLOTS-1:0]         in_wb,
   input  logic [NUM_SLOTS*DATAW-1:0]   in_data,
   output logic [NUM_SLOTS-1:0]         out_valid,
   input  logic [NUM_SLOTS-1:0]         out_ready,
   output logic [NUM_SLOTS*DATAW-1:0]   out_data,
   input  logic [NUM_SLOTS-1:0]         wb_valid,
   input  logic [NUM_SLOTS-1:0]         wb_eop,
   input  logic [NUM_SLOTS*WIS_W-1:0]   wb_wis,
   input  logic [NUM_SLOTS*RW-1:0]      wb_rd,
   input  logic [NUM_SLOTS-1:0]         flush_valid,
   input  logic [NUM_SLOTS*WIS_W-1:0]   flush_wis,
   output logic [NUM_SLOTS*32-1:0]      stall_cycles,
   output logic [NUM_SLOTS-1:0]         err_underflow
);

   localparam logic [CTR_BITS-1:0] CMAX = '1;

   for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
      logic [WIS_W-1:0]    wis, wb_w, fl_w;
      logic [RW-1:0]       rd, rs1, rs2, rs3, wb_r;
      logic [DATAW-1:0]    in_d;
      logic [CTR_BITS-1:0] ctr_q [WARPS_PER_SLOT][NUM_REGS];
      logic [CTR_BITS-1:0] ctr_d [WARPS_PER_SLOT][NUM_REGS];
      logic [CTR_BITS-1:0] rd_cnt_c;
      logic                rs_busy_c, rd_busy_c, busy_c, stage_ready_c, fire_c, pop_c;
      logic                inc_en_c, dec_en_c, same_c, uf_set_c;
      logic                out_valid_q, skid_valid_q, err_q;
      logic [DATAW-1:0]    out_data_q, skid_data_q;
      logic [31:0]         stall_q;

      assign wis  = in_wis[s*WIS_W +: WIS_W];
      assign wb_w = wb_wis[s*WIS_W +: WIS_W];
      assign fl_w = flush_wis[s*WIS_W +: WIS_W];
      assign rd   = in_rd[s*RW +: RW];
      assign rs1  = in_rs1[s*RW +: RW];
      assign rs2  = in_rs2[s*RW +: RW];
      assign rs3  = in_rs3[s*RW +: RW];
      assign wb_r = wb_rd[s*RW +: RW];
      assign in_d = in_data[s*DATAW +: DATAW];

      // Hazard check sees only current counter state; same-cycle writebacks unblock next cycle.
      always_comb begin
         rs_busy_c = (ctr_q[wis][rs1] != '0) || (ctr_q[wis][rs2] != '0) || (ctr_q[wis][rs3] != '0);
         rd_cnt_c  = ctr_q[wis][rd];
         rd_busy_c = (rd_cnt_c == CMAX) || ((ALLOW_WAW == 0) && (rd_cnt_c != '0));
         busy_c    = rs_busy_c || rd_busy_c;
      end

      assign stage_ready_c = ~skid_valid_q;
      assign in_ready[s]   = stage_ready_c & ~busy_c;
      assign fire_c        = in_valid[s] & in_ready[s];
      assign pop_c         = out_valid_q & out_ready[s];

      // Counter next state: flush wins over writeback, same-counter inc/dec cancels.
      always_comb begin
         ctr_d    = ctr_q;
         uf_set_c = 1'b0;
         inc_en_c = fire_c & in_wb[s];
         dec_en_c = wb_valid[s] & wb_eop[s] & ~(flush_valid[s] & (fl_w == wb_w));
         same_c   = inc_en_c & dec_en_c & (wis == wb_w) & (rd == wb_r);
         if (flush_valid[s]) begin
            for (int r = 0; r < NUM_REGS; r++) ctr_d[fl_w][r] = '0;
         end
         if (dec_en_c && !same_c) begin
            if (ctr_q[wb_w][wb_r] == '0) uf_set_c = 1'b1;
            else ctr_d[wb_w][wb_r] = ctr_q[wb_w][wb_r] - CTR_BITS'(1);
         end
         if (inc_en_c && !same_c) begin
            if (flush_valid[s] && (fl_w == wis)) ctr_d[wis][rd] = CTR_BITS'(1);
            else ctr_d[wis][rd] = ctr_q[wis][rd] + CTR_BITS'(1);
         end
      end

      always_ff @(posedge clk) begin
         if (reset) begin
            for (int w = 0; w < WARPS_PER_SLOT; w++)
               for (int r = 0; r < NUM_REGS; r++)
                  ctr_q[w][r] <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            err_q        <= 1'b0;
            stall_q      <= '0;
         end else begin
            ctr_q <= ctr_d;
            if (uf_set_c) err_q <= 1'b1;
            if (in_valid[s] && stage_ready_c && busy_c && (stall_q != '1))
               stall_q <= stall_q + 32'd1;
            if (pop_c) begin
               out_valid_q  <= skid_valid_q | fire_c;
               skid_valid_q <= 1'b0;
            end else if (fire_c) begin
               if (out_valid_q) skid_valid_q <= 1'b1;
               else out_valid_q <= 1'b1;
            end
         end
      end

      // Payload registers carry no reset; validity is tracked by the control flops.
      always_ff @(posedge clk) begin
         if (pop_c) out_data_q <= skid_valid_q ? skid_data_q : in_d;
         else if (fire_c && !out_valid_q) out_data_q <= in_d;
         if (fire_c && out_valid_q && !pop_c) skid_data_q <= in_d;
      end

      assign out_valid[s]                 = out_valid_q;
      assign out_data[s*DATAW +: DATAW]   = out_data_q;
      assign stall_cycles[s*32 +: 32]     = stall_q;
      assign err_underflow[s]             = err_q;
   end

endmodule

// File: tb/tb_vx_pending_scoreboard.sv
// Directed bench for vx_pending_scoreboard: a 2-slot no-WAW instance and a
// 1-slot WAW-permitting instance, probed through in_ready.
module tb_vx_pending_scoreboard;

   logic clk, reset;
   int   passed, total;

   // Instance A: 2 slots, ALLOW_WAW = 0
   logic [1:0]  a_in_valid, a_in_ready, a_in_wb, a_out_valid, a_out_ready;
   logic [1:0]  a_wb_valid, a_wb_eop, a_flush_valid, a_err;
   logic [3:0]  a_in_wis, a_wb_wis, a_flush_wis;
   logic [11:0] a_in_rd, a_in_rs1, a_in_rs2, a_in_rs3, a_wb_rd;
   logic [31:0] a_in_data, a_out_data;
   logic [63:0] a_stall;

   // Instance B: 1 slot, ALLOW_WAW = 1
   logic        b_in_valid, b_in_ready, b_in_wb, b_out_valid, b_out_ready;
   logic        b_wb_valid, b_wb_eop, b_flush_valid, b_err;
   logic [1:0]  b_in_wis, b_wb_wis, b_flush_wis;
   logic [5:0]  b_in_rd, b_in_rs1, b_in_rs2, b_in_rs3, b_wb_rd;
   logic [15:0] b_in_data, b_out_data;
   logic [31:0] b_stall;

   vx_pending_scoreboard #(.NUM_SLOTS(2), .WARPS_PER_SLOT(4), .NUM_REGS(64), .CTR_BITS(2),
                           .ALLOW_WAW(0), .DATAW(16)) dut_a (
      .clk(clk), .reset(reset),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_wis(a_in_wis),
      .in_rd(a_in_rd), .in_rs1(a_in_rs1), .in_rs2(a_in_rs2), .in_rs3(a_in_rs3),
      .in_wb(a_in_wb), .in_data(a_in_data),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
      .wb_valid(a_wb_valid), .wb_eop(a_wb_eop), .wb_wis(a_wb_wis), .wb_rd(a_wb_rd),
      .flush_valid(a_flush_valid), .flush_wis(a_flush_wis),
      .stall_cycles(a_stall), .err_underflow(a_err));

   vx_pending_scoreboard #(.NUM_SLOTS(1), .WARPS_PER_SLOT(4), .NUM_REGS(64), .CTR_BITS(2),
                           .ALLOW_WAW(1), .DATAW(16)) dut_b (
      .clk(clk), .reset(reset),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_wis(b_in_wis),
      .in_rd(b_in_rd), .in_rs1(b_in_rs1), .in_rs2(b_in_rs2), .in_rs3(b_in_rs3),
      .in_wb(b_in_wb), .in_data(b_in_data),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
      .wb_valid(b_wb_valid), .wb_eop(b_wb_eop), .wb_wis(b_wb_wis), .wb_rd(b_wb_rd),
      .flush_valid(b_flush_valid), .flush_wis(b_flush_wis),
      .stall_cycles(b_stall), .err_underflow(b_err));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "bench did not finish");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // rs2/rs3 use registers 61/62, never written; probes use rd 63
   task automatic a_issue(input int s, input logic v, input logic [1:0] w, input logic [5:0] rd,
                          input logic [5:0] rs1, input logic wb, input logic [15:0] d);
      a_in_valid[s]        = v;
      a_in_wis[s*2 +: 2]   = w;
      a_in_rd[s*6 +: 6]    = rd;
      a_in_rs1[s*6 +: 6]   = rs1;
      a_in_rs2[s*6 +: 6]   = 6'd61;
      a_in_rs3[s*6 +: 6]   = 6'd62;
      a_in_wb[s]           = wb;
      a_in_data[s*16 +: 16] = d;
   endtask

   task automatic a_wbk(input logic v, input logic e, input logic [1:0] w, input logic [5:0] r);
      a_wb_valid[0] = v; a_wb_eop[0] = e; a_wb_wis[1:0] = w; a_wb_rd[5:0] = r;
   endtask

   task automatic b_issue(input logic v, input logic [1:0] w, input logic [5:0] rd,
                          input logic [5:0] rs1, input logic wb, input logic [15:0] d);
      b_in_valid = v; b_in_wis = w; b_in_rd = rd; b_in_rs1 = rs1;
      b_in_rs2 = 6'd61; b_in_rs3 = 6'd62; b_in_wb = wb; b_in_data = d;
   endtask

   task automatic b_wbk(input logic v, input logic e, input logic [1:0] w, input logic [5:0] r);
      b_wb_valid = v; b_wb_eop = e; b_wb_wis = w; b_wb_rd = r;
   endtask

   task automatic a_probe(input string tag, input int s, input logic [1:0] w,
                          input logic [5:0] r, input logic exp);
      a_issue(s, 1'b0, w, 6'd63, r, 1'b0, 16'h0);
      #1;
      chk(tag, 64'(a_in_ready[s]), 64'(exp));
   endtask

   task automatic b_probe(input string tag, input logic [1:0] w, input logic [5:0] r, input logic exp);
      b_issue(1'b0, w, 6'd63, r, 1'b0, 16'h0);
      #1;
      chk(tag, 64'(b_in_ready), 64'(exp));
   endtask

   initial begin
      passed = 0; total = 0;
      reset = 1'b1;
      a_in_valid = '0; a_in_wis = '0; a_in_rd = '0; a_in_rs1 = '0; a_in_rs2 = '0; a_in_rs3 = '0;
      a_in_wb = '0; a_in_data = '0; a_out_ready = 2'b11; a_wb_valid = '0; a_wb_eop = '0;
      a_wb_wis = '0; a_wb_rd = '0; a_flush_valid = '0; a_flush_wis = '0;
      b_issue(1'b0, 2'd0, 6'd63, 6'd60, 1'b0, 16'h0);
      b_out_ready = 1'b1; b_wb_valid = 1'b0; b_wb_eop = 1'b0; b_wb_wis = '0; b_wb_rd = '0;
      b_flush_valid = 1'b0; b_flush_wis = '0;
      a_issue(1, 1'b0, 2'd0, 6'd63, 6'd60, 1'b0, 16'h0);
      step(); step();
      chk("rst_a_out_valid", 64'(a_out_valid), 64'(0));
      chk("rst_a_stall", a_stall, 64'(0));
      chk("rst_a_err", 64'(a_err), 64'(0));
      chk("rst_b_out_valid", 64'(b_out_valid), 64'(0));
      reset = 1'b0;
      step();

      // RAW on warp 0, rd 5
      a_issue(0, 1'b1, 2'd0, 6'd5, 6'd60, 1'b1, 16'hA001);
      #1 chk("raw_writer_ready", 64'(a_in_ready[0]), 64'(1));
      step();
      chk("raw_writer_out_valid", 64'(a_out_valid[0]), 64'(1));
      chk("raw_writer_out_data", 64'(a_out_data[15:0]), 64'h0A001);
      a_issue(0, 1'b1, 2'd0, 6'd63, 6'd5, 1'b0, 16'hB002);
      #1 chk("raw_reader_blocked", 64'(a_in_ready[0]), 64'(0));
      step();
      chk("raw_stall1", 64'(a_stall[31:0]), 64'(1));
      step();
      chk("raw_stall2", 64'(a_stall[31:0]), 64'(2));
      a_wbk(1'b1, 1'b1, 2'd0, 6'd5);
      #1 chk("raw_same_cycle_wb_blocked", 64'(a_in_ready[0]), 64'(0));
      step();
      a_wbk(1'b0, 1'b0, 2'd0, 6'd0);
      #1 chk("raw_reader_ready", 64'(a_in_ready[0]), 64'(1));
      chk("raw_stall3", 64'(a_stall[31:0]), 64'(3));
      step();
      chk("raw_reader_out_data", 64'(a_out_data[15:0]), 64'h0B002);
      chk("raw_reader_out_valid", 64'(a_out_valid[0]), 64'(1));
      a_issue(0, 1'b0, 2'd0, 6'd63, 6'd60, 1'b0, 16'h0);
      step();
      chk("raw_drained", 64'(a_out_valid[0]), 64'(0));

      // WAW blocked without ALLOW_WAW
      a_issue(0, 1'b1, 2'd0, 6'd7, 6'd60, 1'b1, 16'hC001);
      #1 chk("waw0_first_ready", 64'(a_in_ready[0]), 64'(1));
      step();
      a_issue(0, 1'b1, 2'd0, 6'd7, 6'd60, 1'b1, 16'hC002);
      #1 chk("waw0_second_blocked", 64'(a_in_ready[0]), 64'(0));
      a_wbk(1'b1, 1'b1, 2'd0, 6'd7);
      step();
      a_wbk(1'b0, 1'b0, 2'd0, 6'd0);
      chk("waw0_stall", 64'(a_stall[31:0]), 64'(4));
      a_probe("waw0_drained", 0, 2'd0, 6'd7, 1'b1);

      // Underflow on slot 0 only
      a_wbk(1'b1, 1'b1, 2'd1, 6'd40);
      step();
      a_wbk(1'b0, 1'b0, 2'd0, 6'd0);
      chk("a_underflow", 64'(a_err), 64'(2'b01));
      a_probe("a_underflow_ctr_zero", 0, 2'd1, 6'd40, 1'b1);

      // Back-pressure: 3 cycles of out_ready = 0
      a_out_ready[0] = 1'b0;
      a_issue(0, 1'b1, 2'd0, 6'd50, 6'd60, 1'b0, 16'h0100);
      #1 chk("bp_accept0", 64'(a_in_ready[0]), 64'(1));
      step();
      a_in_data[15:0] = 16'h0101;
      #1 chk("bp_accept1", 64'(a_in_ready[0]), 64'(1));
      step();
      a_in_data[15:0] = 16'h0102;
      #1 chk("bp_full", 64'(a_in_ready[0]), 64'(0));
      step();
      chk("bp_hold_data", 64'(a_out_data[15:0]), 64'h0100);
      chk("bp_hold_valid", 64'(a_out_valid[0]), 64'(1));
      chk("bp_stall_unchanged", 64'(a_stall[31:0]), 64'(4));
      a_out_ready[0] = 1'b1;
      #1 chk("bp_release_still_full", 64'(a_in_ready[0]), 64'(0));
      step();
      chk("bp_deliver1", 64'(a_out_data[15:0]), 64'h0101);
      step();
      chk("bp_deliver2", 64'(a_out_data[15:0]), 64'h0102);
      a_issue(0, 1'b0, 2'd0, 6'd63, 6'd60, 1'b0, 16'h0);
      step();
      chk("bp_empty", 64'(a_out_valid[0]), 64'(0));
      chk("bp_stall_final", 64'(a_stall[31:0]), 64'(4));

      // Slot independence
      a_issue(0, 1'b1, 2'd0, 6'd9, 6'd60, 1'b1, 16'hD000);
      step();
      a_issue(0, 1'b1, 2'd0, 6'd63, 6'd9, 1'b0, 16'hD001);
      a_issue(1, 1'b1, 2'd0, 6'd63, 6'd9, 1'b0, 16'hE001);
      #1 chk("slot0_blocked", 64'(a_in_ready[0]), 64'(0));
      chk("slot1_free", 64'(a_in_ready[1]), 64'(1));
      step();
      chk("slot1_stall_zero", 64'(a_stall[63:32]), 64'(0));
      chk("slot0_stall", 64'(a_stall[31:0]), 64'(5));
      chk("slot1_out_data", 64'(a_out_data[31:16]), 64'h0E001);

      // Fill both staging buffers, then reset
      a_out_ready = 2'b00;
      a_issue(0, 1'b1, 2'd0, 6'd50, 6'd60, 1'b0, 16'hF000);
      a_issue(1, 1'b1, 2'd0, 6'd50, 6'd60, 1'b0, 16'hF100);
      step();
      a_in_data[15:0] = 16'hF001;
      step();
      chk("full_out_valid", 64'(a_out_valid), 64'(2'b11));
      chk("full_in_ready", 64'(a_in_ready), 64'(2'b00));
      reset = 1'b1;
      a_issue(0, 1'b0, 2'd0, 6'd63, 6'd60, 1'b0, 16'h0);
      a_issue(1, 1'b0, 2'd0, 6'd63, 6'd60, 1'b0, 16'h0);
      step();
      chk("midrst_out_valid", 64'(a_out_valid), 64'(0));
      chk("midrst_stall", a_stall, 64'(0));
      chk("midrst_err", 64'(a_err), 64'(0));
      reset = 1'b0;
      a_out_ready = 2'b11;
      step();
      a_probe("midrst_ctr_cleared", 0, 2'd0, 6'd9, 1'b1);

      // WAW permitted: three writers, fourth blocked at CMAX
      b_issue(1'b1, 2'd0, 6'd7, 6'd60, 1'b1, 16'h7001);
      #1 chk("waw1_w1_ready", 64'(b_in_ready), 64'(1));
      step();
      b_in_data = 16'h7002;
      #1 chk("waw1_w2_ready", 64'(b_in_ready), 64'(1));
      step();
      b_in_data = 16'h7003;
      #1 chk("waw1_w3_ready", 64'(b_in_ready), 64'(1));
      step();
      b_in_data = 16'h7004;
      #1 chk("waw1_w4_blocked", 64'(b_in_ready), 64'(0));
      b_wbk(1'b1, 1'b1, 2'd0, 6'd7);
      step();
      b_wbk(1'b0, 1'b0, 2'd0, 6'd0);
      #1 chk("waw1_w4_ready", 64'(b_in_ready), 64'(1));
      step();
      chk("waw1_w4_out", 64'(b_out_data), 64'h7004);
      b_issue(1'b0, 2'd0, 6'd63, 6'd60, 1'b0, 16'h0);
      b_wbk(1'b1, 1'b1, 2'd0, 6'd7);
      step(); step();
      b_wbk(1'b0, 1'b0, 2'd0, 6'd0);
      b_probe("waw1_one_left", 2'd0, 6'd7, 1'b0);
      b_wbk(1'b1, 1'b1, 2'd0, 6'd7);
      step();
      b_wbk(1'b0, 1'b0, 2'd0, 6'd0);
      b_probe("waw1_drained", 2'd0, 6'd7, 1'b1);
      chk("waw1_stall", 64'(b_stall), 64'(1));

      // Flush warp 2 with concurrent writeback
      b_issue(1'b1, 2'd2, 6'd10, 6'd60, 1'b1, 16'h2001);
      step(); step();
      b_issue(1'b1, 2'd2, 6'd11, 6'd60, 1'b1, 16'h2002);
      step();
      b_issue(1'b1, 2'd1, 6'd10, 6'd60, 1'b1, 16'h1001);
      step();
      b_issue(1'b0, 2'd0, 6'd63, 6'd60, 1'b0, 16'h0);
      b_wbk(1'b1, 1'b0, 2'd2, 6'd11);
      step();
      b_wbk(1'b0, 1'b0, 2'd0, 6'd0);
      b_probe("eop0_no_change", 2'd2, 6'd11, 1'b0);
      b_flush_valid = 1'b1; b_flush_wis = 2'd2;
      b_wbk(1'b1, 1'b1, 2'd2, 6'd10);
      step();
      b_flush_valid = 1'b0;
      b_wbk(1'b0, 1'b0, 2'd0, 6'd0);
      b_probe("flush_w2_r10", 2'd2, 6'd10, 1'b1);
      b_probe("flush_w2_r11", 2'd2, 6'd11, 1'b1);
      chk("flush_no_underflow", 64'(b_err), 64'(0));
      b_probe("flush_w1_kept", 2'd1, 6'd10, 1'b0);

      // Flush concurrent with a writer to the same warp leaves ctr = 1
      b_flush_valid = 1'b1; b_flush_wis = 2'd3;
      b_issue(1'b1, 2'd3, 6'd20, 6'd60, 1'b1, 16'h3001);
      step();
      b_flush_valid = 1'b0;
      b_probe("flush_fire_kept", 2'd3, 6'd20, 1'b0);
      b_wbk(1'b1, 1'b1, 2'd3, 6'd20);
      step();
      b_wbk(1'b1, 1'b1, 2'd1, 6'd10);
      b_probe("flush_fire_one", 2'd3, 6'd20, 1'b1);
      step();
      b_wbk(1'b0, 1'b0, 2'd0, 6'd0);

      // Same-cycle increment and decrement, then underflow
      b_issue(1'b1, 2'd0, 6'd3, 6'd60, 1'b1, 16'h3003);
      step();
      b_wbk(1'b1, 1'b1, 2'd0, 6'd3);
      #1 chk("incdec_fire_ready", 64'(b_in_ready), 64'(1));
      step();
      b_wbk(1'b0, 1'b0, 2'd0, 6'd0);
      b_probe("incdec_ctr_kept", 2'd0, 6'd3, 1'b0);
      b_wbk(1'b1, 1'b1, 2'd0, 6'd3);
      step();
      b_wbk(1'b0, 1'b0, 2'd0, 6'd0);
      b_probe("incdec_ctr_one", 2'd0, 6'd3, 1'b1);
      chk("b_err_before", 64'(b_err), 64'(0));
      b_wbk(1'b1, 1'b1, 2'd0, 6'd3);
      step();
      b_wbk(1'b0, 1'b0, 2'd0, 6'd0);
      chk("b_underflow", 64'(b_err), 64'(1));
      b_probe("b_underflow_ctr_zero", 2'd0, 6'd3, 1'b1);
      step();
      chk("b_underflow_sticky", 64'(b_err), 64'(1));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/vx_pending_scoreboard.md
VX_PENDING_SCOREBOARD -- requirements
Module: VX_pending_scoreboard

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 1, meaning the number of independent issue slots.
REQ-002 SHALL have parameter WARPS_PER_SLOT, default 4, meaning the warps tracked per slot; WIS_W = max(1, clog2(WARPS_PER_SLOT)).
REQ-003 SHALL have parameter NUM_REGS, default 64, meaning the tracked registers per warp; RW = clog2(NUM_REGS).
REQ-004 SHALL have parameter CTR_BITS, default 2, meaning the pending-write counter width; CMAX = 2^CTR_BITS-1.
REQ-005 SHALL have parameter ALLOW_WAW, default 0, meaning that when 1, an rd with pending writes may issue.
REQ-006 SHALL have parameter DATAW, default 64, meaning the opaque payload width.
REQ-007 SHALL have the following ports, per line name direction width meaning; reset is synchronous, active-high; the clock is clk:
 clk  in  1  clock
 reset  in  1  synchronous active-high reset
 in_valid  in  NUM_SLOTS  instruction valid
 in_ready  out  NUM_SLOTS  instruction accepted
 in_wis  in  NUM_SLOTS*WIS_W  warp index in slot
 in_rd, in_rs1, in_rs2, in_rs3  in  NUM_SLOTS*RW each  register indices
 in_wb  in  NUM_SLOTS  instruction writes rd
 in_data  in  NUM_SLOTS*DATAW  payload
 out_valid  out  NUM_SLOTS  staged instruction valid
 out_ready  in  NUM_SLOTS  downstream accept
 out_data  out  NUM_SLOTS*DATAW  staged payload
 wb_valid, wb_eop  in  NUM_SLOTS each  writeback beat, last beat
 wb_wis  in  NUM_SLOTS*WIS_W  writeback warp
 wb_rd  in  NUM_SLOTS*RW  writeback register
 flush_valid  in  NUM_SLOTS  clear all counters of one warp
 flush_wis  in  NUM_SLOTS*WIS_W  warp to clear
 stall_cycles  out  NUM_SLOTS*32  saturating hazard-stall count
 err_underflow  out  NUM_SLOTS  sticky writeback-without-pending flag

Function
REQ-008 SHALL keep, per slot, a CTR_BITS counter for every (warp, register) pair, with slots fully independent.
REQ-009 SHALL flag rsN busy when ctr[wis][rsN] != 0, for N = 1, 2, 3.
REQ-010 SHALL flag rd busy when ctr[wis][rd] == CMAX, or when ALLOW_WAW == 0 and ctr[wis][rd] != 0; rd is checked even when in_wb = 0.
REQ-011 SHALL evaluate the hazard check combinationally from current counter state; writeback or flush in the same cycle does not unblock until the next cycle.
REQ-012 SHALL assert in_ready = stage_ready AND no busy operand; a fire is in_valid AND in_ready.
REQ-013 SHALL increment ctr[wis][rd] by 1 on a fire with in_wb = 1.
REQ-014 SHALL decrement ctr[wb_wis][wb_rd] by 1 when wb_valid AND wb_eop; a beat with wb_eop = 0 SHALL not change state.
REQ-015 SHALL leave the counter unchanged when an increment and a decrement hit the same counter in the same cycle.
REQ-016 SHALL, on a decrement of a zero counter, keep the counter at 0 and set err_underflow, which holds until reset.
REQ-017 SHALL, on flush_valid, clear all counters of flush_wis; a same-cycle writeback to that warp is ignored; a same-cycle fire with in_wb = 1 to that warp leaves its rd counter at 1.
REQ-018 SHALL use a 2-entry skid staging buffer per slot: out_valid and out_data registered, in-to-out latency 1 cycle, full throughput with out_ready held high, stage_ready = not full.
REQ-019 SHALL hold out_data stable while out_valid AND NOT out_ready, and deliver entries in order.
REQ-020 SHALL increment stall_cycles each cycle where in_valid AND stage_ready AND an operand is busy, saturating at 2^32-1; back-pressure-only stalls are not counted.

Reset
REQ-021 SHALL, while reset is high, clear all counters, empty the staging buffers, and drive out_valid = 0, stall_cycles = 0 and err_underflow = 0; in_ready MAY be 1 during reset, but no fire is recorded.
REQ-022 SHALL, on a reset asserted mid-operation, discard staged entries and pending counts with no residual state.

Verification
REQ-023 SHALL pass RAW: issue rd = 5 with wb, warp 0; the next instruction reads rs1 = 5 -> in_ready = 0 and stall_cycles +1 per cycle; wb eop rd = 5 -> the reader fires the following cycle.
REQ-024 SHALL pass WAW: ALLOW_WAW = 1, CTR_BITS = 2; three rd = 7 writers fire back-to-back (ctr = 3); a fourth is blocked; one writeback -> the fourth fires; with ALLOW_WAW = 0 the second writer is blocked.
REQ-025 SHALL pass simultaneous events: a fire with wb on rd = 3 plus a wb eop on rd = 3, same warp, same cycle, with ctr = 1 -> ctr stays 1; a wb with ctr = 0 -> err_underflow = 1 and ctr stays 0.
REQ-026 SHALL pass flush: warp 2 holds ctr[10] = 2 and ctr[11] = 1; flush warp 2 with a concurrent wb to rd = 10 -> all warp 2 counters read 0 next cycle, err_underflow stays 0; warp 1 is unaffected.
REQ-027 SHALL pass back-pressure: out_ready = 0 for 3 cycles with a stream of independent instructions -> exactly 2 accepted, out_data stable, stall_cycles unchanged; on release, in-order delivery with no loss or duplication.
REQ-028 SHALL pass slot independence and reset: NUM_SLOTS = 2, a hazard on slot 0 does not stall slot 1; reset asserted while both staging buffers are full -> out_valid = 0 and counters = 0 the next cycle.
